// File: rtl/uart_receiver_pkg.sv
// Shared encodings and constants for the UART receive path.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int OS_RATE   = 16;
    localparam int DATA_BITS = 8;

    localparam logic [3:0] OS_MID   = 4'd7;
    localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_receiver_sync_fifo.sv
// Small first-word-fall-through FIFO; full/empty derive from the occupancy count.
module uart_receiver_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == {CW{1'b0}});
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling front-end, frame decoder, receive FIFO and error flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rx,
    input  logic          enable,
    input  logic [15:0]   baud_div,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rx_valid,
    output logic [CW-1:0] fifo_count,
    output logic          frame_err,
    output logic          overrun_err,
    input  logic          clear_err,
    output logic          rx_irq
);

    rx_state_e   state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, rx_s;
    logic [15:0] div_cnt_q, div_cnt_d, div_lim_q, div_lim_d;
    logic [3:0]  os_cnt_q, os_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_irq_q, rx_irq_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_err_q, overrun_err_d;
    logic        run, tick, mid_start, sample_bit, sample_stop;
    logic        push, frame_set, overrun_set;
    logic        fifo_full, fifo_empty;

    assign rx_s = sync2_q;
    assign run  = enable & (state_q != ST_IDLE);
    assign tick = run & (div_cnt_q == div_lim_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping enable parks the receiver in IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = rx_s ? ST_IDLE : ST_START;
                ST_START: state_d = mid_start ? (rx_s ? ST_IDLE : ST_DATA) : ST_START;
                ST_DATA:  state_d = (sample_bit && (bit_idx_q == LAST_BIT)) ? ST_STOP : ST_DATA;
                ST_STOP:  state_d = sample_stop ? ST_IDLE : ST_STOP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: sampling strobes and the push/error events they produce.
    always_comb begin
        mid_start   = tick & (state_q == ST_START) & (os_cnt_q == OS_MID);
        sample_bit  = tick & (state_q == ST_DATA)  & (os_cnt_q == OS_LAST);
        sample_stop = tick & (state_q == ST_STOP)  & (os_cnt_q == OS_LAST);
        push        = sample_stop & rx_s;
        frame_set   = sample_stop & ~rx_s;
        overrun_set = push & fifo_full & ~rd_en;
        rx_irq_d    = push & ~overrun_set;
    end

    // Datapath: synchronizer, divider (limit reloads only at wrap), counters, shifter, flags.
    always_comb begin
        sync1_d = uart_rx;
        sync2_d = sync1_q;
        if (!run) begin
            div_cnt_d = 16'd0;
            div_lim_d = baud_div;
        end else if (tick) begin
            div_cnt_d = 16'd0;
            div_lim_d = baud_div;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
            div_lim_d = div_lim_q;
        end
        if ((state_q == ST_IDLE) || !enable || mid_start) begin
            os_cnt_d = 4'd0;
        end else if (tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end else begin
            os_cnt_d = os_cnt_q;
        end
        if (state_q != ST_DATA) begin
            bit_idx_d = 3'd0;
        end else if (sample_bit) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end else begin
            bit_idx_d = bit_idx_q;
        end
        if (sample_bit) begin
            shift_d = {rx_s, shift_q[7:1]};
        end else begin
            shift_d = shift_q;
        end
        frame_err_d   = frame_set   | (frame_err_q   & ~clear_err);
        overrun_err_d = overrun_set | (overrun_err_q & ~clear_err);
    end

    // Datapath registers; the synchronizer resets to the idle line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            div_cnt_q     <= 16'd0;
            div_lim_q     <= 16'd0;
            os_cnt_q      <= 4'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_irq_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            div_cnt_q     <= div_cnt_d;
            div_lim_q     <= div_lim_d;
            os_cnt_q      <= os_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_irq_q      <= rx_irq_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    uart_receiver_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid    = ~fifo_empty;
    assign rx_irq      = rx_irq_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus queues expected bytes, a monitor checks pops and irqs.
module tb_uart_receiver;

    localparam int BIT_CLK  = 64;
    localparam int PUSH_CYC = 9 * BIT_CLK + 34;

    logic        clk = 1'b0;
    logic        reset, uart_rx, enable, rd_en, clear_err;
    logic [15:0] baud_div;
    logic [7:0]  rd_data;
    logic        rx_valid, frame_err, overrun_err, rx_irq;
    logic [2:0]  fifo_count;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int irq_cnt = 0;
    int irq_cyc = 0;
    int exp_irq = 0;
    int start_cyc = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .enable      (enable),
        .baud_div    (baud_div),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .clear_err   (clear_err),
        .rx_irq      (rx_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits of a frame (LSB first), optionally pulsing rd_en / clear_err at a given cycle.
    task automatic drive_line(input logic [9:0] bits, input int nbits, input int pop_cyc,
                              input int clr_cyc);
        for (int k = 0; k < nbits * BIT_CLK; k++) begin
            uart_rx   = bits[k / BIT_CLK];
            rd_en     = (k == pop_cyc);
            clear_err = (k == clr_cyc);
            step(1);
        end
        uart_rx   = 1'b1;
        rd_en     = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit, input logic accept,
                             input int pop_cyc, input int clr_cyc);
        if (accept) begin
            exp_q.push_back(data);
            exp_irq++;
        end
        drive_line({stop_bit, data, 1'b0}, 10, pop_cyc, clr_cyc);
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            step(1);
        end
        rd_en = 1'b0;
    endtask

    // Monitor: counts irq pulses and checks every effective pop against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_irq) begin
                irq_cnt = irq_cnt + 1;
                irq_cyc = cyc;
            end
            if (rd_en && rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop: got 0x%02h with nothing expected", rd_data);
                end else begin
                    check("sb_pop", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        uart_rx   = 1'b1;
        enable    = 1'b1;
        baud_div  = 16'd3;
        rd_en     = 1'b0;
        clear_err = 1'b0;
        step(4);
        reset = 1'b1;
        step(2);
        check("rst_rd_data", rd_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_irq", rx_irq, 0);

        // Single byte, latency and read-out
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1, 1'b1, -1, -1);
        check("irq_latency", irq_cyc - start_cyc, 611);
        check("irq_count_1", irq_cnt, exp_irq);
        check("valid_1", rx_valid, 1);
        check("head_1", rd_data, 8'hA5);
        check("count_1", fifo_count, 1);
        pop_n(1);
        check("valid_after_pop", rx_valid, 0);
        check("count_after_pop", fifo_count, 0);
        pop_n(1);
        check("count_empty_pop", fifo_count, 0);

        // Start-bit glitch
        uart_rx = 1'b0;
        step(20);
        uart_rx = 1'b1;
        step(100);
        check("glitch_count", fifo_count, 0);
        check("glitch_frame_err", frame_err, 0);
        check("glitch_irq", irq_cnt, exp_irq);

        // Framing error and clear
        send_byte(8'h3C, 1'b0, 1'b0, -1, -1);
        step(80);
        check("ferr_set", frame_err, 1);
        check("ferr_count", fifo_count, 0);
        check("ferr_irq", irq_cnt, exp_irq);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("ferr_cleared", frame_err, 0);

        // Overrun: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, (i <= 4), -1, -1);
        end
        step(10);
        check("ovr_count", fifo_count, 4);
        check("ovr_set", overrun_err, 1);
        check("ovr_irq", irq_cnt, exp_irq);
        pop_n(4);
        check("ovr_drained", fifo_count, 0);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("ovr_cleared", overrun_err, 0);

        // Push and pop together while full: no overrun
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 1'b1, (i == 5) ? PUSH_CYC : -1, -1);
        end
        step(10);
        check("pp_count", fifo_count, 4);
        check("pp_no_ovr", overrun_err, 0);
        check("pp_irq", irq_cnt, exp_irq);
        pop_n(4);

        // Reset mid-frame with data and an error pending
        send_byte(8'h11, 1'b1, 1'b1, -1, -1);
        send_byte(8'h3C, 1'b0, 1'b0, -1, -1);
        step(80);
        check("pre_rst_count", fifo_count, 1);
        drive_line({1'b1, 8'h96, 1'b0}, 5, -1, -1);
        reset = 1'b0;
        exp_q.delete();
        step(3);
        reset = 1'b1;
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun_err, 0);
        check("mid_rst_irq", rx_irq, 0);
        step(70);
        send_byte(8'h5A, 1'b1, 1'b1, -1, -1);
        check("post_rst_head", rd_data, 8'h5A);
        pop_n(1);

        // Error set wins over a coincident clear
        send_byte(8'h3C, 1'b0, 1'b0, -1, PUSH_CYC);
        step(80);
        check("coincide_ferr", frame_err, 1);

        // Enable dropped mid-frame
        send_byte(8'h77, 1'b1, 1'b1, -1, -1);
        drive_line({1'b1, 8'hC3, 1'b0}, 5, -1, -1);
        enable  = 1'b0;
        uart_rx = 1'b0;
        step(200);
        uart_rx = 1'b1;
        step(100);
        enable = 1'b1;
        step(100);
        check("en_count", fifo_count, 1);
        check("en_head", rd_data, 8'h77);
        check("en_irq", irq_cnt, exp_irq);
        check("en_ferr_kept", frame_err, 1);
        pop_n(1);

        check("sb_leftover", exp_q.size(), 0);
        check("irq_total", irq_cnt, exp_irq);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
